// File: rtl/writeback_unit_if.sv
// Writeback unit bus: ALU/load handshakes, RegisterFile write port, scoreboard queries.
// q_data1/q_data2 exist only when WB_FWD_EN is defined.
interface writeback_unit_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            ld_valid;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_addr_lo;
  logic            ld_ready;
  logic [4:0]      wsel;
  logic [XLEN-1:0] wdata;
  logic            wen;
  logic [4:0]      q_rs1;
  logic [4:0]      q_rs2;
  logic            q_busy1;
  logic            q_busy2;
`ifdef WB_FWD_EN
  logic [XLEN-1:0] q_data1;
  logic [XLEN-1:0] q_data2;
`endif

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output ld_valid, ld_rd, ld_data,
    output ld_funct3, ld_addr_lo,
    input  ld_ready,
    input  wsel, wdata, wen,
    output q_rs1, q_rs2,
`ifdef WB_FWD_EN
    input  q_data1, q_data2,
`endif
    input  q_busy1, q_busy2
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  ld_valid, ld_rd, ld_data,
    input  ld_funct3, ld_addr_lo,
    output ld_ready,
    output wsel, wdata, wen,
    input  q_rs1, q_rs2,
`ifdef WB_FWD_EN
    output q_data1, q_data2,
`endif
    output q_busy1, q_busy2
  );
endinterface

// File: rtl/writeback_unit.sv
// Merges ALU and load results onto the RegisterFile write port, with ALU FIFO
// and pending-write scoreboard. Define WB_FWD_EN to add q_data forwarding.
module writeback_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  writeback_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]      r_q_rd   [DEPTH];
  logic [XLEN-1:0] r_q_data [DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [CW-1:0]   r_cnt;
  logic            r_wen;
  logic [4:0]      r_wsel;
  logic [XLEN-1:0] r_wdata;

  logic            w_full;
  logic            w_empty;
  logic            w_ready;
  logic            w_sel_head;
  logic            w_sel_ld;
  logic            w_sel_byp;
  logic            w_sel_any;
  logic            w_enq;
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic [AW-1:0]   w_idx [DEPTH];
  logic [4:0]      w_q   [2];
  logic            w_busy [2];

  function automatic logic [XLEN-1:0] fmt_load(
    input logic [XLEN-1:0] d,
    input logic [2:0]      f3,
    input logic [1:0]      lo
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lo, 3'b000} +: 8];
    h = lo[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  fmt_load = {{(XLEN-8){b[7]}}, b};
      3'b001:  fmt_load = {{(XLEN-16){h[15]}}, h};
      3'b100:  fmt_load = {{(XLEN-8){1'b0}}, b};
      3'b101:  fmt_load = {{(XLEN-16){1'b0}}, h};
      default: fmt_load = d;
    endcase
  endfunction

  assign w_full  = r_cnt == CW'(DEPTH);
  assign w_empty = r_cnt == '0;
  assign w_ready = !w_full && !rst;

  assign bus.alu_ready = w_ready;
  assign bus.ld_ready  = w_ready;

  // Full FIFO outranks loads so buffered ALU results cannot starve.
  always_comb begin
    w_sel_head = 1'b0;
    w_sel_ld   = 1'b0;
    w_sel_byp  = 1'b0;
    if (!rst) begin
      if (w_full)            w_sel_head = 1'b1;
      else if (bus.ld_valid) w_sel_ld   = 1'b1;
      else if (!w_empty)     w_sel_head = 1'b1;
      else if (bus.alu_valid) w_sel_byp = 1'b1;
    end
  end

  assign w_sel_any = w_sel_head || w_sel_ld || w_sel_byp;
  assign w_enq     = bus.alu_valid && w_ready && !w_sel_byp;

  always_comb begin
    w_sel_rd   = r_q_rd[r_rp];
    w_sel_data = r_q_data[r_rp];
    unique case (1'b1)
      w_sel_ld: begin
        w_sel_rd   = bus.ld_rd;
        w_sel_data = fmt_load(bus.ld_data, bus.ld_funct3, bus.ld_addr_lo);
      end
      w_sel_byp: begin
        w_sel_rd   = bus.alu_rd;
        w_sel_data = bus.alu_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_rd[r_wp]   <= bus.alu_rd;
      r_q_data[r_wp] <= bus.alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_wen   <= 1'b0;
      r_wsel  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_enq)      r_wp <= r_wp + 1'b1;
      if (w_sel_head) r_rp <= r_rp + 1'b1;
      unique case ({w_enq, w_sel_head})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      r_wen <= w_sel_any && (w_sel_rd != '0);
      if (w_sel_any) begin
        r_wsel  <= w_sel_rd;
        r_wdata <= w_sel_data;
      end
    end
  end

  assign bus.wen   = r_wen;
  assign bus.wsel  = r_wsel;
  assign bus.wdata = r_wdata;

  // w_idx[k] is the k-th oldest FIFO slot.
  for (genvar k = 0; k < DEPTH; k++) begin : g_idx
    assign w_idx[k] = r_rp + AW'(k);
  end

  assign w_q[0] = bus.q_rs1;
  assign w_q[1] = bus.q_rs2;

  always_comb begin
    for (int j = 0; j < 2; j++) begin
      w_busy[j] = r_wen && (r_wsel == w_q[j]);
      for (int k = 0; k < DEPTH; k++) begin
        if (CW'(k) < r_cnt && r_q_rd[w_idx[k]] == w_q[j])
          w_busy[j] = 1'b1;
      end
      if (w_q[j] == '0) w_busy[j] = 1'b0;
    end
  end

  assign bus.q_busy1 = w_busy[0];
  assign bus.q_busy2 = w_busy[1];

`ifdef WB_FWD_EN
  logic [XLEN-1:0] w_fwd [2];

  // Scan oldest to youngest so the newest match wins.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      w_fwd[j] = '0;
      if (r_wen && r_wsel == w_q[j]) w_fwd[j] = r_wdata;
      for (int k = 0; k < DEPTH; k++) begin
        if (CW'(k) < r_cnt && r_q_rd[w_idx[k]] == w_q[j])
          w_fwd[j] = r_q_data[w_idx[k]];
      end
      if (!w_busy[j]) w_fwd[j] = '0;
    end
  end

  assign bus.q_data1 = w_fwd[0];
  assign bus.q_data2 = w_fwd[1];
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed and random stimulus,
// queue-based reference model, decoupled write-port monitor.
module tb_writeback_unit;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_unit_if #(.XLEN(32)) bus();

  writeback_unit #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  wr_t  exp_q[$];
  ent_t mq[$];
  bit          m_wen   = 1'b0;
  logic [4:0]  m_wsel  = '0;
  logic [31:0] m_wdata = '0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [2:0] f3,
                                           input logic [1:0] lo);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * lo)) & 32'hFF;
    h = (d >> (16 * lo[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  function automatic bit m_busy(input logic [4:0] q);
    if (q == 0) return 1'b0;
    if (m_wen && m_wsel == q) return 1'b1;
    foreach (mq[i]) if (mq[i].rd == q) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] q);
    logic [31:0] v;
    v = '0;
    if (!m_busy(q)) return v;
    if (m_wen && m_wsel == q) v = m_wdata;
    foreach (mq[i]) if (mq[i].rd == q) v = mq[i].d;
    return v;
  endfunction

  // Monitor: every write the DUT presents must be the next expected one.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.wen) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_write: got r%0d=%h expected none (cycle %0d)",
                   bus.wsel, bus.wdata, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_sel", {27'd0, bus.wsel}, {27'd0, e.rd});
          chk("wr_data", bus.wdata, e.d);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_write: got wen=0 expected r%0d=%h (cycle %0d)",
                 e.rd, e.d, cyc);
      end
    end
  end

  // One clock cycle: drive, check state-derived outputs, advance the model.
  task automatic step(input bit r, input bit av, input logic [4:0] ard,
                      input logic [31:0] ad, input bit lv, input logic [4:0] lrd,
                      input logic [31:0] ld, input logic [2:0] f3,
                      input logic [1:0] lo, input logic [4:0] q1,
                      input logic [4:0] q2, output bit aacc);
    bit   full;
    bit   sel;
    bit   byp;
    ent_t w;
    rst            = r;
    bus.alu_valid  = av;
    bus.alu_rd     = ard;
    bus.alu_data   = ad;
    bus.ld_valid   = lv;
    bus.ld_rd      = lrd;
    bus.ld_data    = ld;
    bus.ld_funct3  = f3;
    bus.ld_addr_lo = lo;
    bus.q_rs1      = q1;
    bus.q_rs2      = q2;
    #1;
    full = mq.size() == DEPTH;
    chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, !r && !full});
    chk("ld_ready", {31'd0, bus.ld_ready}, {31'd0, !r && !full});
    chk("q_busy1", {31'd0, bus.q_busy1}, {31'd0, m_busy(q1)});
    chk("q_busy2", {31'd0, bus.q_busy2}, {31'd0, m_busy(q2)});
`ifdef WB_FWD_EN
    chk("q_data1", bus.q_data1, m_fwd(q1));
    chk("q_data2", bus.q_data2, m_fwd(q2));
`endif
    aacc = 1'b0;
    if (r) begin
      mq.delete();
      m_wen   = 1'b0;
      m_wsel  = '0;
      m_wdata = '0;
    end else begin
      sel  = 1'b0;
      byp  = 1'b0;
      aacc = av && !full;
      if (full) begin
        w = mq.pop_front(); sel = 1'b1;
      end else if (lv) begin
        w.rd = lrd; w.d = ref_load(ld, f3, lo); sel = 1'b1;
      end else if (mq.size() > 0) begin
        w = mq.pop_front(); sel = 1'b1;
      end else if (av) begin
        w.rd = ard; w.d = ad; sel = 1'b1; byp = 1'b1;
      end
      if (aacc && !byp) mq.push_back('{ard, ad});
      m_wen = sel && w.rd != 0;
      if (sel) begin
        m_wsel  = w.rd;
        m_wdata = w.d;
      end
      if (m_wen) exp_q.push_back('{cyc + 1, w.rd, w.d});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] q1, input int n);
    bit a;
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, q1, 0, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int n;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_data = 0;
    bus.ld_funct3 = 0; bus.ld_addr_lo = 0;
    bus.q_rs1 = 0; bus.q_rs2 = 0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    chk("rst_wen", {31'd0, bus.wen}, 32'd0);
    chk("rst_wsel", {27'd0, bus.wsel}, 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);

    step(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 5, 0, a);
    chk("byp_data", bus.wdata, 32'hDEAD_BEEF);
    chk("byp_busy", {31'd0, bus.q_busy1}, 32'd1);
    idle(5, 2);
    chk("byp_busy_clr", {31'd0, bus.q_busy1}, 32'd0);

    step(0, 1, 15, 32'hAAAA_AAAA, 1, 10, 32'h0000_80FF, 3'b000, 2'd1, 15, 10, a);
    chk("lb_data", bus.wdata, 32'hFFFF_FF80);
    step(0, 0, 0, 0, 1, 11, 32'h8765_4321, 3'b101, 2'd2, 15, 11, a);
    chk("lhu_data", bus.wdata, 32'h0000_8765);
    step(0, 0, 0, 0, 1, 12, 32'h8765_4321, 3'b001, 2'd2, 15, 12, a);
    chk("lh_data", bus.wdata, 32'hFFFF_8765);
    step(0, 0, 0, 0, 1, 13, 32'h8765_4321, 3'b100, 2'd0, 15, 13, a);
    chk("lbu_data", bus.wdata, 32'h0000_0021);
    idle(15, 4);

    n = 0;
    for (int t = 0; t < 40 && n < DEPTH + 1; t++) begin
      step(0, 1, 5'(n + 1), 32'h100 + n, 1, 5'(20 + t % 4), 32'h1000 + t,
           3'b010, 2'd0, 5'(n + 1), 1, a);
      if (a) n++;
    end
    chk("fill_accepted", n, DEPTH + 1);
    for (int t = 0; t < 3; t++)
      step(0, 0, 0, 0, 1, 25, 32'h2000 + t, 3'b010, 0, 1, 2, a);
    idle(1, 10);
    chk("fill_drained", exp_q.size(), 0);

    step(0, 1, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, a);
    chk("rd0_accept", {31'd0, a}, 32'd1);
    chk("rd0_wen", {31'd0, bus.wen}, 32'd0);
    idle(0, 1);

    for (int t = 0; t < 3; t++)
      step(0, 1, 5'(7 + t), 32'h700 + t, 1, 20, 32'h3000 + t, 3'b010, 0, 7, 8, a);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 8, a);
    chk("rst_mid_wen", {31'd0, bus.wen}, 32'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 8, a);
    idle(7, 8);

    for (int t = 0; t < 400; t++) begin
      step(($urandom % 60) == 0, $urandom % 2, 5'($urandom % 8), $urandom,
           ($urandom % 3) == 0, 5'($urandom % 8), $urandom,
           3'($urandom % 8), 2'($urandom % 4),
           5'($urandom % 8), 5'($urandom % 8), a);
    end
    idle(0, 12);
    chk("final_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
